// File: rtl/fm_op_sequencer.sv
// fm_op_sequencer: shares one FM operator across four slots per audio sample.
// Owns per-slot phase/phaseinc/amplitude, routes modulation per algorithm,
// and mixes carrier results into a saturated 16-bit sample.
module fm_op_sequencer #(
  parameter int unsigned NSLOTS     = 4,
  parameter int unsigned OP_LATENCY = 2,
  parameter int unsigned DIV        = 500
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic [1:0]  algo,
  input  logic        trig,
  output logic        op_valid,
  output logic [15:0] op_phase,
  output logic [15:0] op_modin,
  output logic [15:0] op_amplitude,
  input  logic [15:0] op_result,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned WW = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_MIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    algo_q, algo_d;
  logic          pend_q, pend_d;
  logic [15:0]   phase_q [NSLOTS];
  logic [15:0]   phase_d [NSLOTS];
  logic [15:0]   inc_q   [NSLOTS];
  logic [15:0]   inc_d   [NSLOTS];
  logic [15:0]   amp_q   [NSLOTS];
  logic [15:0]   amp_d   [NSLOTS];
  logic [15:0]   res_q   [NSLOTS];
  logic [15:0]   res_d   [NSLOTS];
  logic          op_valid_q, op_valid_d;
  logic [15:0]   op_phase_q, op_phase_d;
  logic [15:0]   op_modin_q, op_modin_d;
  logic [15:0]   op_amp_q, op_amp_d;
  logic [15:0]   sample_q, sample_d;
  logic          sval_q, sval_d;
  logic          ovr_q, ovr_d;

  logic          tick;
  logic          wait_last;
  logic [15:0]   modin;
  logic [1:0]    up_slot;
  logic signed [17:0] mix_sum;
  logic          cfg_addr_unused;

  assign tick            = (cnt_q == CW'(DIV - 1));
  assign wait_last       = (state_q == S_WAIT) && (wcnt_q == WW'(OP_LATENCY - 1));
  assign cfg_addr_unused = cfg_addr[1];

  function automatic logic signed [17:0] sx(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  // State register
  always_ff @(posedge clk24) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: tick starts a sequence, slots 3..0 each ISSUE then WAIT, then MIX
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tick) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_last) state_d = (slot_q == 2'd0) ? S_MIX : S_ISSUE;
      S_MIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    slot_d     = slot_q;
    wcnt_d     = wcnt_q;
    algo_d     = algo_q;
    pend_d     = pend_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    amp_d      = amp_q;
    res_d      = res_q;
    op_valid_d = 1'b0;
    op_phase_d = op_phase_q;
    op_modin_d = op_modin_q;
    op_amp_d   = op_amp_q;
    sample_d   = sample_q;
    sval_d     = 1'b0;
    ovr_d      = ovr_q;
    modin      = '0;
    up_slot    = '0;
    mix_sum    = '0;

    if (cfg_we) begin
      if (cfg_addr[0]) amp_d[cfg_addr[3:2]] = cfg_data;
      else             inc_d[cfg_addr[3:2]] = cfg_data;
    end

    if (tick && (state_q != S_IDLE)) ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          algo_d = algo;
          slot_d = 2'd3;
        end
        if (trig) for (int unsigned i = 0; i < NSLOTS; i++) phase_d[i] = '0;
      end
      S_ISSUE: begin
        phase_d[slot_q] = phase_q[slot_q] + inc_q[slot_q];
        wcnt_d          = '0;
        if (trig) pend_d = 1'b1;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + WW'(1);
        if (trig) pend_d = 1'b1;
        if (wait_last) begin
          res_d[slot_q] = op_result;
          if (slot_q != 2'd0) slot_d = slot_q - 2'd1;
        end
      end
      S_MIX: begin
        // Deferred trig clears on the edge into IDLE, discarding this sequence's phase advance
        if (pend_q || trig) for (int unsigned i = 0; i < NSLOTS; i++) phase_d[i] = '0;
        pend_d = 1'b0;
      end
      default: ;
    endcase

    // Issue values use res_d so a result captured on this edge can feed the next slot
    if (state_d == S_ISSUE) begin
      up_slot = slot_d + 2'd1;
      unique case (algo_d)
        2'd0:    modin = (slot_d == 2'd3) ? '0 : res_d[up_slot];
        2'd1:    modin = (slot_d == 2'd2) ? res_d[3] : ((slot_d == 2'd0) ? res_d[1] : '0);
        2'd2:    modin = '0;
        default: modin = (slot_d == 2'd3) ? '0 : res_d[3];
      endcase
      op_valid_d = 1'b1;
      op_phase_d = phase_q[slot_d];
      op_amp_d   = amp_q[slot_d];
      op_modin_d = modin;
    end

    if (state_d == S_MIX) begin
      unique case (algo_q)
        2'd0:    mix_sum = sx(res_d[0]);
        2'd1:    mix_sum = sx(res_d[0]) + sx(res_d[2]);
        2'd2:    mix_sum = sx(res_d[0]) + sx(res_d[1]) + sx(res_d[2]) + sx(res_d[3]);
        default: mix_sum = sx(res_d[0]) + sx(res_d[1]) + sx(res_d[2]);
      endcase
      sval_d = 1'b1;
      if (mix_sum > 18'sd32767)       sample_d = 16'h7FFF;
      else if (mix_sum < -18'sd32768) sample_d = 16'h8000;
      else                            sample_d = mix_sum[15:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk24) begin
    if (rst) begin
      cnt_q      <= '0;
      slot_q     <= '0;
      wcnt_q     <= '0;
      algo_q     <= '0;
      pend_q     <= 1'b0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        amp_q[i]   <= '0;
        res_q[i]   <= '0;
      end
      op_valid_q <= 1'b0;
      op_phase_q <= '0;
      op_modin_q <= '0;
      op_amp_q   <= '0;
      sample_q   <= '0;
      sval_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      wcnt_q     <= wcnt_d;
      algo_q     <= algo_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      amp_q      <= amp_d;
      res_q      <= res_d;
      op_valid_q <= op_valid_d;
      op_phase_q <= op_phase_d;
      op_modin_q <= op_modin_d;
      op_amp_q   <= op_amp_d;
      sample_q   <= sample_d;
      sval_q     <= sval_d;
      ovr_q      <= ovr_d;
    end
  end

  assign op_valid     = op_valid_q;
  assign op_phase     = op_phase_q;
  assign op_modin     = op_modin_q;
  assign op_amplitude = op_amp_q;
  assign sample_out   = sample_q;
  assign sample_valid = sval_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_fm_op_sequencer.sv
// Bench for fm_op_sequencer: stub operator plus a per-sample reference model.
module tb_fm_op_sequencer;

  logic        clk24 = 1'b0;
  logic        rst, cfg_we, trig;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data, op_result;
  logic [1:0]  algo;
  logic        op_valid, sample_valid, overrun;
  logic [15:0] op_phase, op_modin, op_amplitude, sample_out;

  // Second instance with a too-short sample period
  logic        rst2;
  logic        d2_we = 1'b0, d2_trig = 1'b0;
  logic [3:0]  d2_addr = '0;
  logic [15:0] d2_data = '0, d2_result = '0;
  logic [1:0]  d2_algo = '0;
  logic        d2_valid, d2_sval, overrun2;
  logic [15:0] d2_phase, d2_modin, d2_amp, d2_sample;

  always #5 clk24 = ~clk24;

  fm_op_sequencer u_dut (
    .clk24(clk24), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .algo(algo), .trig(trig), .op_valid(op_valid), .op_phase(op_phase), .op_modin(op_modin),
    .op_amplitude(op_amplitude), .op_result(op_result), .sample_out(sample_out),
    .sample_valid(sample_valid), .overrun(overrun)
  );

  fm_op_sequencer #(.DIV(10)) u_dut2 (
    .clk24(clk24), .rst(rst2), .cfg_we(d2_we), .cfg_addr(d2_addr), .cfg_data(d2_data),
    .algo(d2_algo), .trig(d2_trig), .op_valid(d2_valid), .op_phase(d2_phase), .op_modin(d2_modin),
    .op_amplitude(d2_amp), .op_result(d2_result), .sample_out(d2_sample),
    .sample_valid(d2_sval), .overrun(overrun2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc, t_first, t_sample;

  always @(posedge clk24) cyc <= cyc + 1;

  // Stub operator: 0 = amplitude, 1 = modin+100, 2 = constant, 3 = mixing function
  int          stub_mode = 0;
  logic [15:0] stub_const = '0;

  function automatic logic [15:0] stub_f(input int mode, input logic [15:0] p,
                                         input logic [15:0] m, input logic [15:0] a);
    case (mode)
      0:       return a;
      1:       return m + 16'd100;
      2:       return stub_const;
      default: return (a + {m[15], m[15:1]}) ^ p;
    endcase
  endfunction

  // Result presented from the negedge of the issue cycle and held until the next issue
  always @(negedge clk24) if (op_valid) op_result = stub_f(stub_mode, op_phase, op_modin, op_amplitude);

  // Reference model state
  logic [15:0] ph_m [4];
  logic [15:0] inc_m [4];
  logic [15:0] amp_m [4];
  logic [15:0] seen_ph [4];
  logic [15:0] seen_mi [4];
  logic [15:0] seen_sample;
  // Modulator source per [algo][slot], -1 means none; carrier mask per algo (bit = slot)
  int       src_tab [4][4] = '{'{1, 2, 3, -1}, '{1, -1, 3, -1}, '{-1, -1, -1, -1}, '{3, 3, 3, -1}};
  bit [3:0] out_mask [4]   = '{4'b0001, 4'b0101, 4'b1111, 4'b0111};

  task automatic model_clear_all();
    for (int i = 0; i < 4; i++) begin ph_m[i] = '0; inc_m[i] = '0; amp_m[i] = '0; end
  endtask

  task automatic cfg_write(input int slot, input bit is_amp, input logic [15:0] d);
    @(negedge clk24);
    cfg_we   = 1'b1;
    cfg_addr = {slot[1:0], 1'($urandom_range(0, 1)), is_amp};
    cfg_data = d;
    @(negedge clk24);
    cfg_we = 1'b0;
    if (is_amp) amp_m[slot] = d; else inc_m[slot] = d;
  endtask

  task automatic trig_idle();
    @(negedge clk24); trig = 1'b1;
    @(negedge clk24); trig = 1'b0;
    for (int i = 0; i < 4; i++) ph_m[i] = '0;
  endtask

  task automatic run_sample(input logic [1:0] a, input int mode, input bit trig_mid);
    logic [15:0] res [4];
    logic [15:0] e_ph [4];
    logic [15:0] e_mi [4];
    logic [15:0] e_amp [4];
    logic [15:0] es;
    int sum, exp_s, prev, s;
    bit got;
    algo = a;
    stub_mode = mode;
    sum = 0;
    prev = 0;
    for (int k = 3; k >= 0; k--) begin
      e_ph[k]  = ph_m[k];
      e_amp[k] = amp_m[k];
      e_mi[k]  = (src_tab[a][k] >= 0) ? res[src_tab[a][k]] : 16'h0;
      res[k]   = stub_f(mode, e_ph[k], e_mi[k], e_amp[k]);
      ph_m[k]  = ph_m[k] + inc_m[k];
      if (out_mask[a][k]) sum += int'($signed(res[k]));
    end
    exp_s = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
    es = exp_s[15:0];
    for (int n = 0; n < 4; n++) begin
      s = 3 - n;
      got = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
        @(negedge clk24);
        if (op_valid) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL issue_timeout slot %0d: op_valid not seen, required within 600 cycles", s);
      end else begin
        if (n == 0) t_first = cyc;
        else begin
          checks++;
          if (cyc - prev !== 3) begin
            errors++;
            $display("FAIL issue_spacing slot %0d: got %0d cycles, required 3", s, cyc - prev);
          end
        end
        prev = cyc;
        checks++;
        if (op_phase !== e_ph[s]) begin
          errors++;
          $display("FAIL op_phase slot %0d: got %h, required %h", s, op_phase, e_ph[s]);
        end
        checks++;
        if (op_modin !== e_mi[s]) begin
          errors++;
          $display("FAIL op_modin slot %0d algo %0d: got %h, required %h", s, a, op_modin, e_mi[s]);
        end
        checks++;
        if (op_amplitude !== e_amp[s]) begin
          errors++;
          $display("FAIL op_amplitude slot %0d: got %h, required %h", s, op_amplitude, e_amp[s]);
        end
        seen_ph[s] = op_phase;
        seen_mi[s] = op_modin;
      end
      if (n == 0 && trig_mid) begin
        @(negedge clk24); trig = 1'b1;
        @(negedge clk24); trig = 1'b0;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk24);
      if (sample_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL sample_timeout: sample_valid not seen, required after last issue");
    end else begin
      t_sample = cyc;
      seen_sample = sample_out;
      checks++;
      if (sample_out !== es) begin
        errors++;
        $display("FAIL sample_out algo %0d mode %0d: got %h, required %h", a, mode, sample_out, es);
      end
      checks++;
      if (t_sample - t_first !== 12) begin
        errors++;
        $display("FAIL sample_latency: got %0d cycles after first issue, required 12", t_sample - t_first);
      end
    end
    if (trig_mid) for (int i = 0; i < 4; i++) ph_m[i] = '0;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk24);
    checks++;
    if ({op_valid, sample_valid, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 000", {op_valid, sample_valid, overrun});
    end
    checks++;
    if ({op_phase, op_modin, op_amplitude, sample_out} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {op_phase, op_modin, op_amplitude, sample_out});
    end
    checks++;
    if (overrun2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun2: got %b, required 0", overrun2);
    end
    model_clear_all();
    @(negedge clk24);
    rst = 1'b0;
    rst2 = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic test_timing();
    for (int s = 0; s < 4; s++) cfg_write(s, 1'b1, 16'(s * 1000));
    run_sample(2'd2, 0, 1'b0);
    checks++;
    if (t_first - rel_cyc !== 500) begin
      errors++;
      $display("FAIL first_issue: got %0d cycles after reset, required 500", t_first - rel_cyc);
    end
  endtask

  task automatic test_algo2();
    run_sample(2'd2, 0, 1'b0);
    checks++;
    if (seen_sample !== 16'd6000) begin
      errors++;
      $display("FAIL algo2_mix: got %0d, required 6000", seen_sample);
    end
  endtask

  task automatic test_chain();
    run_sample(2'd0, 1, 1'b0);
    checks++;
    if ({seen_mi[0], seen_mi[1], seen_mi[2], seen_mi[3]} !== {16'd300, 16'd200, 16'd100, 16'd0}) begin
      errors++;
      $display("FAIL algo0_modins: got %0d %0d %0d %0d, required 300 200 100 0",
               seen_mi[0], seen_mi[1], seen_mi[2], seen_mi[3]);
    end
    checks++;
    if (seen_sample !== 16'd400) begin
      errors++;
      $display("FAIL algo0_mix: got %0d, required 400", seen_sample);
    end
    // pairs: res3=100, res2=200, res1=100, res0=200 -> carriers 2+0 = 400
    run_sample(2'd1, 1, 1'b0);
    checks++;
    if (seen_sample !== 16'd400) begin
      errors++;
      $display("FAIL algo1_mix: got %0d, required 400", seen_sample);
    end
  endtask

  task automatic test_saturation();
    stub_const = 16'd30000;
    run_sample(2'd2, 2, 1'b0);
    checks++;
    if (seen_sample !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_pos: got %h, required 7fff", seen_sample);
    end
    stub_const = 16'hFFFF - 16'd29999;
    run_sample(2'd2, 2, 1'b0);
    checks++;
    if (seen_sample !== 16'h8000) begin
      errors++;
      $display("FAIL sat_neg: got %h, required 8000", seen_sample);
    end
  endtask

  task automatic test_phase_trig();
    logic [15:0] exp_a [3];
    logic [15:0] exp_b [3];
    exp_a = '{16'd0, 16'd2404, 16'd4808};
    exp_b = '{16'h0000, 16'hFFFF, 16'hFFFE};
    trig_idle();
    cfg_write(0, 1'b0, 16'd2404);
    for (int i = 0; i < 3; i++) begin
      run_sample(2'd2, 0, 1'b0);
      checks++;
      if (seen_ph[0] !== exp_a[i]) begin
        errors++;
        $display("FAIL phase_step %0d: got %0d, required %0d", i, seen_ph[0], exp_a[i]);
      end
    end
    trig_idle();
    cfg_write(0, 1'b0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      run_sample(2'd2, 0, 1'b0);
      checks++;
      if (seen_ph[0] !== exp_b[i]) begin
        errors++;
        $display("FAIL phase_wrap %0d: got %h, required %h", i, seen_ph[0], exp_b[i]);
      end
    end
    for (int s = 1; s < 4; s++) cfg_write(s, 1'b0, 16'($urandom_range(1, 65535)));
    run_sample(2'd3, 3, 1'b1);
    run_sample(2'd0, 3, 1'b0);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seen_ph[s] !== 16'h0) begin
        errors++;
        $display("FAIL trig_mid_clear slot %0d: got %h, required 0000", s, seen_ph[s]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 2; w++)
        cfg_write($urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 5) == 0) trig_idle();
      run_sample(2'($urandom_range(0, 3)), 3, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    bit got, bad;
    algo = 2'd0;
    stub_mode = 3;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk24);
      if (op_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL midrst_issue_timeout: op_valid not seen, required within 600 cycles");
    end
    @(negedge clk24); rst = 1'b1;
    @(negedge clk24); rst = 1'b0;
    rel_cyc = cyc;
    model_clear_all();
    checks++;
    if ({op_valid, overrun, op_phase, sample_out} !== 34'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h, required 0", {op_valid, overrun, op_phase, sample_out});
    end
    bad = 1'b0;
    for (int i = 0; i < 480; i++) begin
      @(negedge clk24);
      if (sample_valid || op_valid) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet: got strobe before next tick, required none");
    end
    run_sample(2'd2, 0, 1'b0);
    checks++;
    if (t_first - rel_cyc !== 500) begin
      errors++;
      $display("FAIL midrst_first_issue: got %0d cycles after reset, required 500", t_first - rel_cyc);
    end
  endtask

  task automatic test_overrun();
    bit got, dropped;
    @(negedge clk24); rst2 = 1'b1;
    @(negedge clk24);
    @(negedge clk24);
    checks++;
    if (overrun2 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_reset: got %b, required 0", overrun2);
    end
    rst2 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk24);
      if (overrun2) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL overrun_set: got 0 after 60 cycles, required 1");
    end
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk24);
      if (overrun2 !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL overrun_sticky: got 0 during hold, required 1");
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_main: got %b, required 0", overrun);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    algo = '0; trig = 1'b0; op_result = '0;
    test_reset();
    test_timing();
    test_algo2();
    test_chain();
    test_saturation();
    test_phase_trig();
    test_random();
    test_mid_reset();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
